// File: rtl/decode_ctrl.sv
// Two-entry in-order decode buffer (main + skid) that tags each beat with its RISC-V format.
// Optional macro DECODE_ILLEGAL_CHK_EN adds a stored per-entry illegal-opcode flag.
module decode_ctrl #(
    parameter int ILEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [ILEN-1:0] in_instr,
    input  logic [ILEN-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [ILEN-1:0] out_instr,
    output logic [ILEN-1:0] out_pc,
    output logic [2:0]      out_fmt,
    output logic            out_illegal
);

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] TWO   = 2'd2;

    typedef struct packed {
        logic [ILEN-1:0] instr;
        logic [ILEN-1:0] pc;
        logic [2:0]      fmt;
`ifdef DECODE_ILLEGAL_CHK_EN
        logic            ill;
`endif
    } entry_t;

    function automatic logic [2:0] fmt_of(input logic [6:0] op);
        case (op)
            7'b0110011:                                     fmt_of = 3'd0;
            7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: fmt_of = 3'd1;
            7'b0100011:                                     fmt_of = 3'd2;
            7'b1100011:                                     fmt_of = 3'd3;
            7'b0110111, 7'b0010111:                         fmt_of = 3'd4;
            7'b1101111:                                     fmt_of = 3'd5;
            default:                                        fmt_of = 3'd7;
        endcase
    endfunction

    // Format (and illegal flag) are decided once at write time so the head stays stable.
    function automatic entry_t mk_entry(input logic [ILEN-1:0] instr, input logic [ILEN-1:0] pc);
        entry_t e;
        e.instr = instr;
        e.pc    = pc;
        e.fmt   = fmt_of(instr[6:0]);
`ifdef DECODE_ILLEGAL_CHK_EN
        e.ill   = (e.fmt == 3'd7) || (instr[1:0] != 2'b11);
`endif
        return e;
    endfunction

    logic [1:0] state, state_n;
    entry_t     main_q, main_n, skid_q, skid_n;
    logic       accept, drain;

    assign accept = in_valid && in_ready;
    assign drain  = out_valid && out_ready;

    always_comb begin
        state_n = state;
        main_n  = main_q;
        skid_n  = skid_q;
        if (flush) begin
            state_n = EMPTY;
            main_n  = '0;
            skid_n  = '0;
        end else begin
            case (state)
                EMPTY: if (accept) begin
                    state_n = ONE;
                    main_n  = mk_entry(in_instr, in_pc);
                end
                ONE: begin
                    if (accept && !drain) begin
                        state_n = TWO;
                        skid_n  = mk_entry(in_instr, in_pc);
                    end else if (accept && drain) begin
                        main_n  = mk_entry(in_instr, in_pc);
                    end else if (drain) begin
                        state_n = EMPTY;
                        main_n  = '0;
                    end
                end
                TWO: if (drain) begin
                    state_n = ONE;
                    main_n  = skid_q;
                    skid_n  = '0;
                end
                default: begin
                    state_n = EMPTY;
                    main_n  = '0;
                    skid_n  = '0;
                end
            endcase
        end
    end

    // Handshake flags are registered copies of the next-state decode.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= EMPTY;
            main_q    <= '0;
            skid_q    <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_n;
            main_q    <= main_n;
            skid_q    <= skid_n;
            in_ready  <= (state_n != TWO);
            out_valid <= (state_n != EMPTY);
        end
    end

    assign out_instr = main_q.instr;
    assign out_pc    = main_q.pc;
    assign out_fmt   = main_q.fmt;
`ifdef DECODE_ILLEGAL_CHK_EN
    assign out_illegal = main_q.ill;
`else
    assign out_illegal = 1'b0;
`endif

endmodule
